// File: rtl/alu_regfile_wb.sv
// Operand register file plus single-entry write-back pipe around the ALU; reads are combinational with forwarding.
// A write is captured at edge N, forwarded in cycle N+1 and committed at edge N+1; write-back is never stalled.
module alu_regfile_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        wb_flags,
  input  logic              flags_we,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [1:0]        flags,
  output logic              wb_pending
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  // Old pending entry commits on the same edge that captures the new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      flags      <= 2'b00;
    end else begin
      pend_valid <= wb_valid;
      if (wb_valid) begin
        pend_addr <= wb_addr;
        pend_data <= wb_data;
      end
      if (pend_valid && (pend_addr != '0)) regs[pend_addr] <= pend_data;
      if (wb_valid && flags_we) flags <= wb_flags;
    end
  end

  always_comb begin
    operand1 = regs[rd_addr1];
    if (rd_addr1 == '0)
      operand1 = '0;
    else if (pend_valid && (pend_addr == rd_addr1))
      operand1 = pend_data;
  end

  always_comb begin
    operand2 = regs[rd_addr2];
    if (rd_addr2 == '0)
      operand2 = '0;
    else if (pend_valid && (pend_addr == rd_addr2))
      operand2 = pend_data;
  end

  assign wb_pending = pend_valid;

endmodule

// File: tb/tb_alu_regfile_wb.sv
// Bench for alu_regfile_wb: architectural "latest write wins" model plus directed literal pins and random traffic.
module tb_alu_regfile_wb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wb_valid = 1'b0;
  logic [1:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic [1:0] wb_flags = '0;
  logic       flags_we = 1'b0;
  logic [1:0] rd_addr1 = '0;
  logic [1:0] rd_addr2 = '0;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [1:0] flags;
  logic       wb_pending;

  always #5 clk = ~clk;

  alu_regfile_wb #(.DATA_W(8), .ADDR_W(2), .NREGS(4)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_flags(wb_flags), .flags_we(flags_we),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .operand1(operand1),
    .operand2(operand2), .flags(flags), .wb_pending(wb_pending)
  );

  // With forwarding, the visible register value is simply the most recent write.
  logic [7:0] m_val [4];
  logic       m_pend;
  logic [1:0] m_flags;
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] m_rd(input logic [1:0] a);
    return (a == 2'd0) ? 8'h00 : m_val[a];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_val[i] = 8'h00;
    m_pend  = 1'b0;
    m_flags = 2'b00;
  endtask

  task automatic compare();
    chk("operand1", operand1, m_rd(rd_addr1));
    chk("operand2", operand2, m_rd(rd_addr2));
    chk("flags", {6'b0, flags}, {6'b0, m_flags});
    chk("wb_pending", {7'b0, wb_pending}, {7'b0, m_pend});
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [7:0] d,
                       input logic [1:0] f, input logic fwe,
                       input logic [1:0] r1, input logic [1:0] r2);
    wb_valid = v; wb_addr = a; wb_data = d; wb_flags = f; flags_we = fwe;
    rd_addr1 = r1; rd_addr2 = r2;
  endtask

  task automatic settle();
    #1;
    compare();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (!reset) begin
      m_pend = wb_valid;
      if (wb_valid) begin
        if (wb_addr != 2'd0) m_val[wb_addr] = wb_data;
        if (flags_we) m_flags = wb_flags;
      end
    end
    @(negedge clk);
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
  endtask

  logic [7:0] sum;

  initial begin
    model_reset();
    settle();
    chk("rst_op1", operand1, 8'h00);
    chk("rst_pending", {7'b0, wb_pending}, 8'h00);
    clk_edge();
    reset = 1'b0;

    // Reset mid-write discards the pending entry.
    drive(1'b1, 2'd2, 8'h5A, 2'b10, 1'b1, 2'd2, 2'd2);
    settle();
    clk_edge();
    drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b0, 2'd2, 2'd2);
    settle();
    chk("fwd_5a", operand1, 8'h5A);
    mid_reset();
    chk("rstmid_pending", {7'b0, wb_pending}, 8'h00);
    chk("rstmid_flags", {6'b0, flags}, 8'h00);
    clk_edge();
    reset = 1'b0;
    settle();
    chk("rst_r2", operand1, 8'h00);
    clk_edge();

    // Write latency: forwarded then from the array.
    drive(1'b1, 2'd1, 8'h3C, 2'b00, 1'b0, 2'd1, 2'd0);
    settle();
    clk_edge();
    drive(1'b0, 2'd3, 8'hEE, 2'b11, 1'b1, 2'd1, 2'd0);
    settle();
    chk("lat_n1", operand1, 8'h3C);
    chk("lat_pend_n1", {7'b0, wb_pending}, 8'h01);
    clk_edge();
    settle();
    chk("lat_n2", operand1, 8'h3C);
    chk("lat_pend_n2", {7'b0, wb_pending}, 8'h00);
    clk_edge();

    // Back-to-back writes to R3.
    drive(1'b1, 2'd3, 8'h11, 2'b00, 1'b0, 2'd3, 2'd3);
    settle();
    clk_edge();
    drive(1'b1, 2'd3, 8'h22, 2'b00, 1'b0, 2'd3, 2'd3);
    settle();
    chk("b2b_op1_n1", operand1, 8'h11);
    chk("b2b_op2_n1", operand2, 8'h11);
    clk_edge();
    drive(1'b0, 2'd1, 8'h99, 2'b00, 1'b0, 2'd3, 2'd3);
    settle();
    chk("b2b_op1_n2", operand1, 8'h22);
    chk("b2b_op2_n2", operand2, 8'h22);
    clk_edge();
    settle();
    chk("b2b_array", operand2, 8'h22);
    clk_edge();

    // R0 immunity.
    drive(1'b1, 2'd0, 8'hFF, 2'b00, 1'b0, 2'd0, 2'd0);
    settle();
    clk_edge();
    drive(1'b0, 2'd0, 8'hFF, 2'b00, 1'b0, 2'd0, 2'd0);
    settle();
    chk("r0_op1", operand1, 8'h00);
    chk("r0_pending", {7'b0, wb_pending}, 8'h01);
    clk_edge();
    settle();
    chk("r0_op2", operand2, 8'h00);
    clk_edge();

    // Flag gating.
    drive(1'b1, 2'd1, 8'h3C, 2'b10, 1'b1, 2'd1, 2'd2);
    clk_edge();
    settle();
    chk("flg_set", {6'b0, flags}, 8'h02);
    drive(1'b1, 2'd1, 8'h3C, 2'b00, 1'b0, 2'd1, 2'd2);
    clk_edge();
    settle();
    chk("flg_no_we", {6'b0, flags}, 8'h02);
    drive(1'b0, 2'd1, 8'h3C, 2'b00, 1'b1, 2'd1, 2'd2);
    clk_edge();
    settle();
    chk("flg_no_valid", {6'b0, flags}, 8'h02);

    // ALU loop: 7F + 01 -> 80 with overflow.
    drive(1'b1, 2'd1, 8'h7F, 2'b00, 1'b1, 2'd1, 2'd2);
    clk_edge();
    drive(1'b1, 2'd2, 8'h01, 2'b00, 1'b0, 2'd1, 2'd2);
    clk_edge();
    drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b0, 2'd1, 2'd2);
    settle();
    chk("alu_op1", operand1, 8'h7F);
    chk("alu_op2", operand2, 8'h01);
    chk("alu_flags_pre", {6'b0, flags}, 8'h00);
    sum = operand1 + operand2;
    drive(1'b1, 2'd3, sum, 2'b10, 1'b1, 2'd3, 2'd3);
    clk_edge();
    drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b0, 2'd3, 2'd1);
    settle();
    chk("alu_r3", operand1, 8'h80);
    chk("alu_flags", {6'b0, flags}, 8'h02);
    clk_edge();

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom));
      settle();
      if ($urandom_range(0, 39) == 0) mid_reset();
      clk_edge();
      reset = 1'b0;
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
